// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The opcode constants and select codes are kept here so the top and the ALU decoder agree on them.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_ADR,
        S_JALR_LINK,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multicycle controller and its datapath/memory.
// master = the controller, slave = the datapath side that consumes the strobes.
interface multicycle_ctrl_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        AdrSrc;
    logic        Retire;
    logic        Halted;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, Retire, Halted,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, instret
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc, Retire, Halted,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, instret
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps the controller's coarse ALUOp plus funct fields to ALUControl.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) can encode sub; addi with imm[10]=1 stays add.
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/writeback and counts retired instructions.
// All strobes are masked while rst is high so an aborted access never writes.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_instret;
    logic [1:0]  w_alu_op;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [1:0]  w_result_src;
    logic        w_pc_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_mem_write;
    logic        w_mem_read;
    logic        w_adr_src;
    logic        w_retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_adr_src    = 1'b0;
        w_retire     = 1'b0;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_result_src = RES_ALUOUT;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_read   = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                if (bus.mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
                    OP_RTYPE:          w_state_next = S_EXECUTER;
                    OP_ITYPE:          w_state_next = S_EXECUTEI;
                    OP_BRANCH:         w_state_next = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
                    OP_JAL:            w_state_next = S_JAL;
                    OP_JALR:           w_state_next = S_JALR_ADR;
                    default:           w_state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src  = 1'b1;
                w_mem_read = 1'b1;
                if (bus.mem_ready) w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_MEMDATA;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (bus.mem_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
                w_alu_op     = ALUOP_FUNCT;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_result_src = RES_ALUOUT;
                // funct3[0] selects bne over beq; the target already sits in ALUOut from DECODE.
                w_pc_write   = bus.funct3[0] ? ~bus.zero : bus.zero;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL, S_JALR_LINK: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_write   = 1'b1;
                w_state_next = S_ALUWB;
            end
            S_JALR_ADR: begin
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_state_next = S_JALR_LINK;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    mc_alu_dec u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (bus.funct3),
        .i_op5         (bus.op[5]),
        .i_funct7b5    (bus.funct7b5),
        .o_alu_control (bus.ALUControl)
    );

    assign bus.PCWrite   = w_pc_write  & ~rst;
    assign bus.IRWrite   = w_ir_write  & ~rst;
    assign bus.RegWrite  = w_reg_write & ~rst;
    assign bus.MemWrite  = w_mem_write & ~rst;
    assign bus.MemRead   = w_mem_read  & ~rst;
    assign bus.Retire    = w_retire    & ~rst;
    assign bus.Halted    = (r_state == S_HALT) & ~rst;
    assign bus.AdrSrc    = w_adr_src;
    assign bus.ALUSrcA   = w_alu_src_a;
    assign bus.ALUSrcB   = w_alu_src_b;
    assign bus.ResultSrc = w_result_src;
    assign bus.ImmSrc    = imm_src(bus.op);
    assign bus.instret   = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction paths are expanded into phase lists, expected outputs
// are queued per cycle by the driver and compared by an independent negedge monitor.
module tb_multicycle_ctrl;

    typedef enum int {
        P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB, P_MWR, P_EXR, P_EXI,
        P_AWB, P_BR, P_JAL, P_JADR, P_JLNK, P_HALT
    } ph_t;

    typedef struct {
        ph_t         ph;
        logic [18:0] vec;
        logic [31:0] instret;
    } exp_t;

    logic clk = 1'b1;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;
    int          force_wait = -1;
    int          force_zero = -1;

    function automatic string ph_name(input ph_t p);
        case (p)
            P_FETCH: return "FETCH";
            P_DEC:   return "DECODE";
            P_MADR:  return "MEMADR";
            P_MRD:   return "MEMREAD";
            P_MWB:   return "MEMWB";
            P_MWR:   return "MEMWRITE";
            P_EXR:   return "EXECUTER";
            P_EXI:   return "EXECUTEI";
            P_AWB:   return "ALUWB";
            P_BR:    return "BRANCH";
            P_JAL:   return "JAL";
            P_JADR:  return "JALR_ADR";
            P_JLNK:  return "JALR_LINK";
            default: return "HALT";
        endcase
    endfunction

    // Vector layout: pcw irw rw mw mr adr ret hlt | srcA srcB res imm | aluctl
    function automatic logic [18:0] model_out(input ph_t ph, input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7, input logic z, input logic rdy, input logic in_rst);
        logic pcw, irw, rw, mw, mr, adr, ret, hlt;
        logic [1:0] sa, sb, rs, imm, aop;
        logic [2:0] aluc;
        {pcw, irw, rw, mw, mr, adr, ret, hlt} = 8'b0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; aop = 2'b00;
        case (ph)
            P_FETCH: begin mr = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            P_DEC:   begin sa = 2'b01; sb = 2'b01; end
            P_MADR:  begin sa = 2'b10; sb = 2'b01; end
            P_MRD:   begin adr = 1; mr = 1; end
            P_MWB:   begin rs = 2'b01; rw = 1; ret = 1; end
            P_MWR:   begin adr = 1; mw = 1; ret = rdy; end
            P_EXR:   begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
            P_EXI:   begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            P_AWB:   begin rw = 1; ret = 1; end
            P_BR:    begin sa = 2'b10; aop = 2'b01; ret = 1; pcw = (f3 == 3'b000) ? z : ~z; end
            P_JAL, P_JLNK: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            P_JADR:  begin sa = 2'b10; sb = 2'b01; end
            default: hlt = 1;
        endcase
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        if (aop == 2'b01) aluc = 3'b001;
        else if (aop == 2'b00) aluc = 3'b000;
        else if (f3 == 3'b000) aluc = (o[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) aluc = 3'b101;
        else if (f3 == 3'b110) aluc = 3'b011;
        else if (f3 == 3'b111) aluc = 3'b010;
        else aluc = 3'b000;
        if (in_rst) {pcw, irw, rw, mw, mr, ret, hlt} = 7'b0;
        return {pcw, irw, rw, mw, mr, adr, ret, hlt, sa, sb, rs, imm, aluc};
    endfunction

    function automatic logic [18:0] act_vec();
        return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.AdrSrc,
                bus.Retire, bus.Halted, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a full output vector every cycle; compare it away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({"outputs ", ph_name(e.ph)}, {13'd0, act_vec()}, {13'd0, e.vec});
                check({"instret ", ph_name(e.ph)}, bus.instret, e.instret);
            end
        end
    end

    function automatic logic pick_zero();
        if (force_zero < 0) return 1'($urandom_range(0, 1));
        return (force_zero != 0);
    endfunction

    task automatic push_only(input ph_t ph, input logic rdy, input logic z);
        exp_t e;
        bus.mem_ready = rdy;
        bus.zero      = z;
        e.ph      = ph;
        e.vec     = model_out(ph, bus.op, bus.funct3, bus.funct7b5, z, rdy, rst);
        e.instret = model_cnt;
        q.push_back(e);
    endtask

    task automatic step(input ph_t ph, input logic rdy, input logic z);
        logic [18:0] v;
        push_only(ph, rdy, z);
        v = model_out(ph, bus.op, bus.funct3, bus.funct7b5, z, rdy, rst);
        @(posedge clk);
        #1;
        if (v[12]) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        model_cnt = '0;
        repeat (n) step(P_FETCH, 1'($urandom_range(0, 1)), 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        ph_t         path[$];
        int          cyc;
        logic [31:0] start_cnt;
        logic        rdy;
        int          waited;
        cyc = 0;
        start_cnt = model_cnt;
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
        path.push_back(P_FETCH);
        path.push_back(P_DEC);
        case (o)
            7'b0000011: begin path.push_back(P_MADR); path.push_back(P_MRD); path.push_back(P_MWB); end
            7'b0100011: begin path.push_back(P_MADR); path.push_back(P_MWR); end
            7'b0110011: begin path.push_back(P_EXR); path.push_back(P_AWB); end
            7'b0010011: begin path.push_back(P_EXI); path.push_back(P_AWB); end
            7'b1100011: path.push_back((f3 == 3'b000 || f3 == 3'b001) ? P_BR : P_HALT);
            7'b1101111: begin path.push_back(P_JAL); path.push_back(P_AWB); end
            7'b1100111: begin path.push_back(P_JADR); path.push_back(P_JLNK); path.push_back(P_AWB); end
            default:    path.push_back(P_HALT);
        endcase
        foreach (path[i]) begin
            if (path[i] inside {P_FETCH, P_MRD, P_MWR}) begin
                waited = 0;
                do begin
                    if (force_wait < 0) rdy = ($urandom_range(0, 99) < 65);
                    else rdy = (path[i] == P_FETCH) ? 1'b1 : (waited >= force_wait);
                    step(path[i], rdy, pick_zero());
                    cyc++;
                    waited++;
                end while (!rdy);
            end else if (path[i] == P_HALT) begin
                repeat (10) begin
                    step(P_HALT, 1'($urandom_range(0, 1)), pick_zero());
                    cyc++;
                end
            end else begin
                step(path[i], 1'($urandom_range(0, 1)), pick_zero());
                cyc++;
            end
        end
        $display("instr op=%b f3=%b f7=%b last=%s cycles=%0d instret %0d->%0d",
                 o, f3, f7, ph_name(path[path.size()-1]), cyc, start_cnt, model_cnt);
        if (path[path.size()-1] == P_HALT) reset_dut(2);
    endtask

    // A store stalled in MEMWRITE is hit by rst mid-cycle: its write strobe must drop at once.
    task automatic store_reset();
        bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
        step(P_FETCH, 1'b1, 1'b0);
        step(P_DEC, 1'b1, 1'b0);
        step(P_MADR, 1'b1, 1'b0);
        step(P_MWR, 1'b0, 1'b0);
        push_only(P_MWR, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_midwait MemWrite", {31'd0, bus.MemWrite}, 32'd0);
        check("rst_midwait Retire", {31'd0, bus.Retire}, 32'd0);
        check("rst_midwait ResultSrc", {30'd0, bus.ResultSrc}, 32'd2);
        @(posedge clk);
        #1;
        reset_dut(1);
        $display("instr store aborted by rst in MEMWRITE wait");
    endtask

    logic [6:0] op_tab [0:6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1100111};

    initial begin
        logic [6:0] o;
        logic [2:0] f3;
        bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_dut(2);

        force_wait = 2;
        run_instr(7'b0000011, 3'b010, 1'b0);           // lw, MEMREAD x3
        force_wait = 0;
        force_zero = 0; run_instr(7'b1100011, 3'b001, 1'b0);  // bne taken
        force_zero = 1; run_instr(7'b1100011, 3'b001, 1'b0);  // bne not taken
        force_zero = 1; run_instr(7'b1100011, 3'b000, 1'b0);  // beq taken
        force_zero = -1;
        run_instr(7'b1100111, 3'b000, 1'b0);           // jalr
        run_instr(7'b0110011, 3'b000, 1'b1);           // sub
        run_instr(7'b0110011, 3'b111, 1'b0);           // and
        run_instr(7'b0010011, 3'b000, 1'b1);           // addi with imm bit 10 set
        run_instr(7'b0110111, 3'b000, 1'b0);           // lui -> HALT, then reset
        run_instr(7'b1100011, 3'b100, 1'b0);           // blt -> HALT
        store_reset();
        force_wait = -1;

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 99) < 4) begin
                o = 7'($urandom_range(0, 127));
            end else begin
                o = op_tab[$urandom_range(0, 6)];
            end
            f3 = 3'($urandom_range(0, 7));
            if (o == 7'b1100011 && $urandom_range(0, 9) != 0) f3 = {2'b00, f3[0]};
            run_instr(o, f3, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        check("queue_drain", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
